// File: rtl/fir_ahb_pkg.sv
// Shared definitions for the AHB-Lite FIR engine: register map, bus encodings, MAC states.
package fir_ahb_pkg;

    // Register byte offsets (halfword aligned)
    localparam int OFF_STATUS = 'h00;
    localparam int OFF_RESULT = 'h02;
    localparam int OFF_SAMPLE = 'h04;
    localparam int OFF_CTRL   = 'h06;
    localparam int OFF_COEF   = 'h20;

    // STATUS bit positions
    localparam int ST_BUSY   = 0;
    localparam int ST_ERR    = 1;
    localparam int ST_RVALID = 2;

    // CTRL bit positions
    localparam int CTRL_CLR_ERR = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DONE
    } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// One-tap-per-cycle multiply-accumulate sequencer with output scaling and saturation.
module fir_mac_unit
    import fir_ahb_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_TAPS = 4,
    localparam int CNT_W    = $clog2(NUM_TAPS)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x_tap,
    input  logic signed [DATA_W-1:0] c_tap,
    output logic        [CNT_W-1:0]  tap_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic signed [DATA_W-1:0] result
);

    localparam int ACC_W = 2*DATA_W + CNT_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state;
    state_t                    state_nxt;
    logic        [CNT_W-1:0]   cnt;
    logic                      last_tap;
    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [ACC_W-1:0]   acc_nxt;

    // Drop the Q(DATA_W-1) fraction of the coefficient product
    function automatic logic signed [ACC_W-1:0] scale_acc(input logic signed [ACC_W-1:0] a);
        return a >>> (DATA_W-1);
    endfunction

    function automatic logic sat_ovf(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = scale_acc(a);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = scale_acc(a);
        if (s > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    // stage p0: product of the selected tap
    assign prod_p0  = x_tap * c_tap;
    assign acc_nxt  = acc_p1 + ACC_W'(prod_p0);
    assign last_tap = (cnt == CNT_W'(NUM_TAPS-1));
    assign tap_idx  = cnt;
    assign busy     = (state != IDLE);
    assign ovf      = done && sat_ovf(acc_nxt);

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; done flags the last accumulate so the result lands as DONE begins
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = MAC;
            MAC: begin
                if (last_tap) begin
                    done      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // stage p1: accumulator, tap counter and saturated result
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_p1 <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                LOAD: begin
                    acc_p1 <= '0;
                    cnt    <= '0;
                end
                MAC: begin
                    acc_p1 <= acc_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_tap)
                        result <= sat_q(acc_nxt);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_lite_fir_engine.sv
// AHB-Lite slave wrapping the FIR coefficient bank, delay line, status/result registers and MAC.
module ahb_lite_fir_engine
    import fir_ahb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 4,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hsize,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hresp,
    output logic              irq
);

    localparam int CNT_W = $clog2(NUM_TAPS);

    logic                     accept;
    logic                     vld_p1;
    logic                     wr_p1;
    logic                     size_p1;
    logic [ADDR_W-1:0]        addr_p1;
    logic [ADDR_W-1:0]        off;

    logic signed [DATA_W-1:0] coef [NUM_TAPS];
    logic signed [DATA_W-1:0] x_dl [NUM_TAPS];
    logic                     result_valid;
    logic                     err_flag;
    logic                     irq_q;

    logic                     sel_status, sel_result, sel_sample, sel_ctrl, sel_coef;
    logic                     mapped, bad;
    logic [CNT_W-1:0]         coef_idx;
    logic [DATA_W-1:0]        rd_val;
    logic [DATA_W-1:0]        wval;
    logic                     do_wr, do_rd;

    logic [CNT_W-1:0]         tap_idx;
    logic                     mac_busy, mac_done, mac_ovf;
    logic signed [DATA_W-1:0] mac_result;

    // Byte writes replace only the addressed lane of the current register value
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic              full,
                                                     input logic              hi);
        logic [DATA_W-1:0] m;
        m = old_v;
        if (full)
            m = new_v;
        else if (hi)
            m[DATA_W-1:8] = new_v[DATA_W-1:8];
        else
            m[7:0] = new_v[7:0];
        return m;
    endfunction

    assign accept = hsel && ((htrans == HT_NONSEQ) || (htrans == HT_SEQ));
    assign irq    = irq_q;

    // stage p1: capture the address phase
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            vld_p1  <= 1'b0;
            wr_p1   <= 1'b0;
            size_p1 <= 1'b0;
            addr_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                wr_p1   <= hwrite;
                size_p1 <= hsize;
                addr_p1 <= haddr;
            end
        end
    end

    // Data-phase decode, read mux and error response
    always_comb begin
        off        = {addr_p1[ADDR_W-1:1], 1'b0};
        sel_status = (off == ADDR_W'(OFF_STATUS));
        sel_result = (off == ADDR_W'(OFF_RESULT));
        sel_sample = (off == ADDR_W'(OFF_SAMPLE));
        sel_ctrl   = (off == ADDR_W'(OFF_CTRL));
        sel_coef   = 1'b0;
        coef_idx   = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (off == ADDR_W'(OFF_COEF + 2*k)) begin
                sel_coef = 1'b1;
                coef_idx = CNT_W'(k);
            end
        end
        mapped = sel_status || sel_result || sel_sample || sel_ctrl || sel_coef;

        rd_val = '0;
        if (sel_status) begin
            rd_val[ST_BUSY]   = mac_busy;
            rd_val[ST_ERR]    = err_flag;
            rd_val[ST_RVALID] = result_valid;
        end else if (sel_result) begin
            rd_val = mac_result;
        end else if (sel_sample) begin
            rd_val = x_dl[0];
        end else if (sel_coef) begin
            rd_val = coef[coef_idx];
        end

        wval = lane_merge(rd_val, hwdata, size_p1, addr_p1[0]);

        bad = vld_p1 && (!mapped
                         || (wr_p1 && (sel_status || sel_result))
                         || (wr_p1 && mac_busy &&
                             (sel_sample || sel_coef || (sel_ctrl && wval[CTRL_FLUSH]))));

        do_wr  = vld_p1 && wr_p1 && !bad;
        do_rd  = vld_p1 && !wr_p1 && !bad;
        hresp  = bad;
        hrdata = do_rd ? rd_val : '0;
    end

    // Register file, coefficient bank, delay line and completion flags
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= '0;
                x_dl[k] <= '0;
            end
            result_valid <= 1'b0;
            err_flag     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= mac_done;

            if (do_wr && sel_coef)
                coef[coef_idx] <= wval;

            if (do_wr && sel_sample) begin
                for (int k = NUM_TAPS-1; k > 0; k--)
                    x_dl[k] <= x_dl[k-1];
                x_dl[0] <= wval;
            end else if (do_wr && sel_ctrl && wval[CTRL_FLUSH]) begin
                for (int k = 0; k < NUM_TAPS; k++)
                    x_dl[k] <= '0;
            end

            // A fresh overflow wins over a simultaneous clear request
            if (mac_ovf)
                err_flag <= 1'b1;
            else if (do_wr && sel_ctrl && wval[CTRL_CLR_ERR])
                err_flag <= 1'b0;

            // A fresh result wins over a simultaneous RESULT read
            if (mac_done)
                result_valid <= 1'b1;
            else if (do_rd && sel_result)
                result_valid <= 1'b0;
        end
    end

    fir_mac_unit #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_mac (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (do_wr && sel_sample),
        .x_tap   (x_dl[tap_idx]),
        .c_tap   (coef[tap_idx]),
        .tap_idx (tap_idx),
        .busy    (mac_busy),
        .done    (mac_done),
        .ovf     (mac_ovf),
        .result  (mac_result)
    );

endmodule
